// File: rtl/pipe_test_sequencer_if.sv
`default_nettype none
// pipe_test_sequencer_if: host/checker-facing signal bundle for the Pipe In test sequencer.
// master = host side driving the pass, slave = the sequencer itself.
interface pipe_test_sequencer_if #(
   parameter int LEN_W = 32,
   parameter int TMO_W = 24
);
   logic             start;
   logic             abort;
   logic             cfg_mode;
   logic [31:0]      cfg_throttle;
   logic [LEN_W-1:0] cfg_length;
   logic [TMO_W-1:0] cfg_timeout;
   logic             pipe_in_write;
   logic [31:0]      chk_error_count;
   logic             chk_reset;
   logic             chk_throttle_set;
   logic [31:0]      chk_throttle_val;
   logic             chk_mode;
   logic             busy;
   logic             done;
   logic [1:0]       status;
   logic [LEN_W-1:0] words_done;
   logic [31:0]      errors_latched;
   logic [31:0]      run_cycles;

   modport master (
      output start, abort, cfg_mode, cfg_throttle, cfg_length, cfg_timeout,
             pipe_in_write, chk_error_count,
      input  chk_reset, chk_throttle_set, chk_throttle_val, chk_mode, busy, done,
             status, words_done, errors_latched, run_cycles
   );

   modport slave (
      input  start, abort, cfg_mode, cfg_throttle, cfg_length, cfg_timeout,
             pipe_in_write, chk_error_count,
      output chk_reset, chk_throttle_set, chk_throttle_val, chk_mode, busy, done,
             status, words_done, errors_latched, run_cycles
   );
endinterface
`default_nettype wire

// File: rtl/pipe_test_sequencer.sv
`default_nettype none
// pipe_test_sequencer: runs one Pipe In test pass (reset/arm checker, count writes, report status).
// Define PIPE_SEQ_CYCLE_COUNT_EN to build the RUN-cycle counter; otherwise run_cycles reads 0.
module pipe_test_sequencer #(
   parameter int LEN_W = 32,
   parameter int TMO_W = 24
) (
   input  wire logic            clk,
   input  wire logic            reset,
   pipe_test_sequencer_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RST1   = 3'd1,
      S_RST2   = 3'd2,
      S_ARM    = 3'd3,
      S_RUN    = 3'd4,
      S_SETTLE = 3'd5,
      S_REPORT = 3'd6
   } state_t;

   state_t           state_q;
   logic             chk_reset_q, throttle_set_q, mode_q, busy_q, done_q;
   logic             aborted_q, timeout_q;
   logic [31:0]      throttle_q, errors_q;
   logic [LEN_W-1:0] length_q, words_q, words_d;
   logic [TMO_W-1:0] tmo_q, idle_q, idle_d;
   logic [1:0]       status_q, status_d;
   logic             aborted_d, len_hit, tmo_hit;

   always_comb begin
      words_d = words_q;
      if (bus.pipe_in_write && (words_q != '1))
         words_d = words_q + LEN_W'(1);
      idle_d = idle_q;
      if (bus.pipe_in_write)
         idle_d = '0;
      else if (idle_q != '1)
         idle_d = idle_q + TMO_W'(1);
      // A zero length exits on the first RUN cycle without any write.
      len_hit   = (words_q == length_q) || (words_d == length_q);
      tmo_hit   = (tmo_q != '0) && (idle_d == tmo_q);
      aborted_d = aborted_q | bus.abort;
      if (aborted_d)
         status_d = 2'd3;
      else if (timeout_q)
         status_d = 2'd2;
      else if (bus.chk_error_count != 32'd0)
         status_d = 2'd1;
      else
         status_d = 2'd0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         chk_reset_q    <= 1'b1;
         throttle_set_q <= 1'b0;
         mode_q         <= 1'b0;
         throttle_q     <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         status_q       <= 2'd0;
         words_q        <= '0;
         errors_q       <= '0;
         length_q       <= '0;
         tmo_q          <= '0;
         idle_q         <= '0;
         aborted_q      <= 1'b0;
         timeout_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               chk_reset_q <= 1'b0;
               if (bus.start) begin
                  state_q     <= S_RST1;
                  chk_reset_q <= 1'b1;
                  busy_q      <= 1'b1;
                  mode_q      <= bus.cfg_mode;
                  throttle_q  <= bus.cfg_throttle;
                  length_q    <= bus.cfg_length;
                  tmo_q       <= bus.cfg_timeout;
                  words_q     <= '0;
                  idle_q      <= '0;
                  aborted_q   <= 1'b0;
                  timeout_q   <= 1'b0;
               end
            end
            S_RST1: begin
               if (bus.abort) begin
                  state_q     <= S_SETTLE;
                  chk_reset_q <= 1'b0;
                  aborted_q   <= 1'b1;
               end else begin
                  state_q <= S_RST2;
               end
            end
            S_RST2: begin
               chk_reset_q <= 1'b0;
               if (bus.abort) begin
                  state_q   <= S_SETTLE;
                  aborted_q <= 1'b1;
               end else begin
                  state_q        <= S_ARM;
                  throttle_set_q <= 1'b1;
               end
            end
            S_ARM: begin
               throttle_set_q <= 1'b0;
               if (bus.abort) begin
                  state_q   <= S_SETTLE;
                  aborted_q <= 1'b1;
               end else begin
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               if (words_q != length_q)
                  words_q <= words_d;
               idle_q <= idle_d;
               if (bus.abort) begin
                  state_q   <= S_SETTLE;
                  aborted_q <= 1'b1;
               end else if (len_hit) begin
                  state_q <= S_SETTLE;
               end else if (tmo_hit) begin
                  state_q   <= S_SETTLE;
                  timeout_q <= 1'b1;
               end
            end
            S_SETTLE: begin
               // Error count is sampled here so the checker's final registered update is included.
               errors_q  <= bus.chk_error_count;
               status_q  <= status_d;
               aborted_q <= aborted_d;
               done_q    <= 1'b1;
               state_q   <= S_REPORT;
            end
            S_REPORT: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef PIPE_SEQ_CYCLE_COUNT_EN
   logic [31:0] run_cycles_q;
   always_ff @(posedge clk) begin
      if (reset)
         run_cycles_q <= '0;
      else if ((state_q == S_IDLE) && bus.start)
         run_cycles_q <= '0;
      else if ((state_q == S_RUN) && (run_cycles_q != '1))
         run_cycles_q <= run_cycles_q + 32'd1;
   end
   assign bus.run_cycles = run_cycles_q;
`else
   assign bus.run_cycles = '0;
`endif

   assign bus.chk_reset        = chk_reset_q;
   assign bus.chk_throttle_set = throttle_set_q;
   assign bus.chk_throttle_val = throttle_q;
   assign bus.chk_mode         = mode_q;
   assign bus.busy             = busy_q;
   assign bus.done             = done_q;
   assign bus.status           = status_q;
   assign bus.words_done       = words_q;
   assign bus.errors_latched   = errors_q;
endmodule
`default_nettype wire

// File: tb/tb_pipe_test_sequencer.sv
`default_nettype none
// tb_pipe_test_sequencer: directed and randomized passes checked against a pass-outcome model.
module tb_pipe_test_sequencer;
   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   tests = 0;
   int   failed = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pipe_test_sequencer_if #(.LEN_W(32), .TMO_W(24)) bus ();

   pipe_test_sequencer #(.LEN_W(32), .TMO_W(24)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.start         = 1'b0;
      bus.abort         = 1'b0;
      bus.pipe_in_write = 1'b0;
   endtask

   // One complete pass. Expected outcome is derived from what the bench actually drove.
   task automatic do_pass(input string name, input bit mode, input logic [31:0] thr,
                          input logic [31:0] len, input logic [23:0] tmo, input int n_wr,
                          input int gmin, input int gmax, input int err_after,
                          input logic [31:0] err_val, input int abort_after,
                          input bit abort_early, input bit noise);
      int n_start, run_start, issued, last_wr, abort_cyc, done_cyc, gap, budget;
      int exp_exit, exp_status, exp_rc;
      logic [31:0] exp_err;
      @(negedge clk);
      idle_inputs();
      bus.start           = 1'b1;
      bus.cfg_mode        = mode;
      bus.cfg_throttle    = thr;
      bus.cfg_length      = len;
      bus.cfg_timeout     = tmo;
      bus.chk_error_count = 32'd0;
      n_start   = cyc;
      run_start = n_start + 4;
      issued = 0; last_wr = -1; abort_cyc = -1; done_cyc = -1;
      gap    = int'($urandom_range(gmax, gmin));
      budget = 20 + n_wr * (gmax + 1) + int'(tmo);
      for (int k = 1; k < budget && done_cyc < 0; k++) begin
         @(negedge clk);
         if (k == 1) begin
            check({name, ":busy_n1"}, bus.busy, 1);
            check({name, ":chk_mode"}, bus.chk_mode, mode);
            check({name, ":chk_throttle_val"}, bus.chk_throttle_val, thr);
            bus.cfg_mode     = ~mode;
            bus.cfg_throttle = $urandom;
            bus.cfg_length   = $urandom;
            bus.cfg_timeout  = 24'($urandom);
         end
         if (k <= 3) begin
            check({name, ":chk_reset"}, bus.chk_reset, (k <= 2) ? 1 : 0);
            check({name, ":chk_throttle_set"}, bus.chk_throttle_set,
                  (k == 3 && !abort_early) ? 1 : 0);
         end
         if (bus.done) done_cyc = cyc;
         idle_inputs();
         if (done_cyc >= 0) continue;
         if (noise && k <= 3) bus.pipe_in_write = 1'($urandom_range(1, 0));
         if (noise && k >= 4) bus.start = 1'($urandom_range(1, 0));
         if (abort_early && k == 2) begin
            bus.abort = 1'b1;
            abort_cyc = cyc;
         end else if (!abort_early && k >= 4 && abort_cyc < 0) begin
            if (abort_after >= 0 && issued == abort_after) begin
               bus.abort = 1'b1;
               abort_cyc = cyc;
            end else if (issued < n_wr) begin
               if (gap == 0) begin
                  bus.pipe_in_write = 1'b1;
                  issued++;
                  last_wr = cyc;
                  gap = int'($urandom_range(gmax, gmin));
                  if (err_after > 0 && issued == err_after) bus.chk_error_count = err_val;
               end else begin
                  gap--;
               end
            end
         end
      end

      exp_err = (err_after > 0 && issued >= err_after) ? err_val : 32'd0;
      if (abort_cyc >= 0) begin
         exp_exit = abort_cyc; exp_status = 3;
      end else if (issued == int'(len)) begin
         exp_exit = (len == 0) ? run_start : last_wr;
         exp_status = (exp_err != 0) ? 1 : 0;
      end else begin
         exp_exit = ((last_wr < 0) ? run_start - 1 : last_wr) + int'(tmo);
         exp_status = 2;
      end
`ifdef PIPE_SEQ_CYCLE_COUNT_EN
      exp_rc = (exp_exit >= run_start) ? exp_exit - run_start + 1 : 0;
`else
      exp_rc = 0;
`endif
      check({name, ":done_seen"}, (done_cyc >= 0) ? 1 : 0, 1);
      check({name, ":done_cycle"}, 64'(done_cyc - n_start), 64'(exp_exit + 2 - n_start));
      check({name, ":busy_report"}, bus.busy, 1);
      check({name, ":status"}, bus.status, 64'(exp_status));
      check({name, ":words_done"}, bus.words_done, 64'(issued));
      check({name, ":errors_latched"}, bus.errors_latched, exp_err);
      check({name, ":run_cycles"}, bus.run_cycles, 64'(exp_rc));
      check({name, ":chk_throttle_hold"}, bus.chk_throttle_val, thr);
      @(negedge clk);
      check({name, ":done_pulse"}, bus.done, 0);
      check({name, ":busy_after"}, bus.busy, 0);
      check({name, ":status_hold"}, bus.status, 64'(exp_status));
      check({name, ":words_hold"}, bus.words_done, 64'(issued));
   endtask

   initial begin
      int l, nw, ea, ab;
      bit short_run;
      logic [23:0] t;
      reset = 1'b1;
      idle_inputs();
      bus.cfg_mode = 1'b0; bus.cfg_throttle = '0; bus.cfg_length = '0;
      bus.cfg_timeout = '0; bus.chk_error_count = '0;
      repeat (3) @(negedge clk);
      check("rst:chk_reset", bus.chk_reset, 1);
      check("rst:chk_throttle_set", bus.chk_throttle_set, 0);
      check("rst:chk_throttle_val", bus.chk_throttle_val, 0);
      check("rst:chk_mode", bus.chk_mode, 0);
      check("rst:busy", bus.busy, 0);
      check("rst:done", bus.done, 0);
      check("rst:status", bus.status, 0);
      check("rst:words_done", bus.words_done, 0);
      check("rst:errors_latched", bus.errors_latched, 0);
      check("rst:run_cycles", bus.run_cycles, 0);
      reset = 1'b0;
      @(negedge clk);
      check("idle:chk_reset", bus.chk_reset, 0);
      check("idle:busy", bus.busy, 0);

      do_pass("pass",    1'b1, 32'hFFFF_FFFF, 1024, 100, 1024, 0, 2, 0, 0, -1, 1'b0, 1'b0);
      do_pass("dataerr", 1'b1, 32'hFFFF_FFFF, 1024, 100, 1024, 0, 2, 500, 3, -1, 1'b0, 1'b0);
      do_pass("timeout", 1'b0, $urandom, 1024, 50, 10, 0, 2, 0, 0, -1, 1'b0, 1'b1);
      do_pass("abort",   1'b1, $urandom, 1024, 100, 1024, 0, 1, 0, 0, 200, 1'b0, 1'b0);
      do_pass("len0",    1'b0, 32'h1234_5678, 0, 20, 0, 0, 1, 0, 0, -1, 1'b0, 1'b0);
      do_pass("cycles",  1'b1, 32'hAAAA_AAAA, 64, 10, 64, 1, 1, 0, 0, -1, 1'b0, 1'b0);
      do_pass("abort_rst", 1'b0, $urandom, 100, 10, 100, 0, 1, 0, 0, -1, 1'b1, 1'b1);
      do_pass("tmo_nowr", 1'b1, $urandom, 5, 7, 0, 0, 1, 0, 0, -1, 1'b0, 1'b0);

      for (int p = 0; p < 6; p++) begin
         l = int'($urandom_range(150, 1));
         short_run = ($urandom_range(2, 0) == 0);
         nw = short_run ? int'($urandom_range(32'(l - 1), 0)) : l;
         t = (short_run || $urandom_range(1, 0) == 1) ? 24'($urandom_range(30, 5)) : 24'd0;
         ea = (nw > 0 && $urandom_range(1, 0) == 1) ? int'($urandom_range(32'(nw), 1)) : 0;
         ab = (!short_run && l > 1 && $urandom_range(3, 0) == 0) ?
              int'($urandom_range(32'(l - 1), 0)) : -1;
         do_pass("random", 1'($urandom_range(1, 0)), $urandom, 32'(l), t, nw, 0, 3,
                 ea, $urandom_range(255, 1), ab, 1'b0, 1'($urandom_range(1, 0)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
`default_nettype wire
